wts_channel_mixer: RTL and testbench
====================================

Name: wts_channel_mixer

Overview:
- Downstream consumer of the per-channel `channel` output produced by the channel volume stage.
- Receives one time-multiplexed, signed 8-bit sample per channel per sample frame.
- Applies a per-channel mute mask, sums the frame, and scales the sum by a 4-bit master volume.
- Saturates the result to the output width and presents one registered mixed sample per frame to the DAC/output stage, with a one-cycle valid strobe.

Parameters:
- CH_NUM, 5: number of channels per frame; the channel index space is 0..CH_NUM-1.
- OUT_BITS, 11: width of the signed mixed output. Legal range 8..11.

Ports:
- clk  input  1  system clock.
- nreset  input  1  reset. Synchronous, active-low: sampled only on rising clk.
- ch_valid  input  1  one-cycle strobe; `channel` and `ch_index` are valid this cycle.
- ch_last  input  1  qualifies ch_valid; marks the final channel of the frame.
- ch_index  input  3  index of the channel currently presented.
- channel  input  8  signed channel sample (two's complement).
- reg_mute  input  CH_NUM  bit n=1 mutes channel n.
- reg_master  input  4  master volume, 0..15.
- mix_out  output  OUT_BITS  signed mixed sample; holds its value between frames.
- mix_valid  output  1  one-cycle pulse when mix_out updates.
- err_overrun  output  1  sticky flag: a sample arrived while the mixer was busy.

Behaviour:
- Reset (nreset=0 at a rising clk):
  - State goes to IDLE; accumulator (11-bit signed) = 0; scaled register = 0.
  - mix_out = 0, mix_valid = 0, err_overrun = 0.
  - Reset mid-frame discards the partial sum; no output is produced for that frame.
- State machine: IDLE -> ACCUM -> SCALE -> OUTPUT -> IDLE.
  - IDLE:
    - On ch_valid: acc <= effective sample (load, not add).
    - If ch_last=1 in the same cycle: go to SCALE; otherwise go to ACCUM.
  - ACCUM:
    - On ch_valid: acc <= acc + effective sample.
    - If ch_last=1: go to SCALE. With no ch_valid, acc and state hold.
  - SCALE (1 cycle):
    - scaled <= (acc * (reg_master + 1)) >>> 4, with a 16-bit signed product.
    - Arithmetic shift: rounds toward minus infinity.
    - reg_master is sampled in this cycle only.
  - OUTPUT (1 cycle):
    - mix_out <= saturate(scaled, OUT_BITS); mix_valid = 1 for exactly this cycle.
    - Next state is IDLE.
- Effective sample:
  - 0 if reg_mute[ch_index]=1 or ch_index >= CH_NUM.
  - Otherwise `channel` sign-extended to 11 bits.
  - reg_mute is sampled on the same cycle as ch_valid.
- Width rules:
  - Worst-case sum for CH_NUM=5 is -640..+635, which fits 11 bits without wrap.
  - Saturation clamps to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1].
- Latency: ch_valid & ch_last at rising edge T -> mix_out/mix_valid visible after edge T+2.
- Overrun:
  - ch_valid while in SCALE or OUTPUT: the sample is dropped and err_overrun is set.
  - err_overrun stays set until reset. The in-flight result is unaffected.
  - The next frame begins at the first ch_valid after returning to IDLE.
- Channel count: the frame ends only on ch_last. The number of strobes per frame is not checked; any count >= 1 is accepted.
- No back-pressure: mix_valid is not acknowledged, and the downstream stage must capture mix_out on the pulse.

Test Plan:
1. Reset, then CH_NUM=5 samples 10,20,30,40,50 (ch_last on index 4), reg_master=15, reg_mute=0 -> mix_valid 2 cycles after the last strobe, mix_out=150, err_overrun=0.
2. Same frame with reg_master=7 -> mix_out=75. Then reg_master=0 and a single-sample frame of -1 (ch_last on the first strobe) -> mix_out=-1, confirming floor rounding and the IDLE->SCALE path.
3. Same frame as 1 with reg_mute=5'b00100 -> mix_out=120. Then a frame with ch_index=6 carrying 100 plus index 0 carrying 5 -> mix_out=5.
4. All five samples -128, reg_master=15: with OUT_BITS=11 -> mix_out=-640; with OUT_BITS=8 -> mix_out=-128. All samples +127 with OUT_BITS=8 -> mix_out=127.
5. Strobe ch_valid (value 99) on the cycle after ch_last, i.e. during SCALE -> err_overrun=1 and stays 1; mix_out=150 for the frame of test 1. The next frame of 1,2,3,4,5 -> 15.
6. Assert nreset=0 after 3 of 5 samples -> the next edge gives mix_out=0, mix_valid=0, err_overrun=0. Release reset and send a full frame of 10s -> mix_out=50, with no contribution from the aborted frame.

Source files
------------

// File: rtl/wts_channel_mixer.sv
// wts_channel_mixer: collects one time-multiplexed signed 8-bit sample per
// channel and masks muted or out-of-range channels. At the end of each frame
// it scales the sum by a 4-bit master volume, saturates it to OUT_BITS and
// presents it with a one-cycle valid pulse.
module wts_channel_mixer #(
  parameter int CH_NUM   = 5,
  parameter int OUT_BITS = 11
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                ch_valid,
  input  logic                ch_last,
  input  logic [2:0]          ch_index,
  input  logic [7:0]          channel,
  input  logic [CH_NUM-1:0]   reg_mute,
  input  logic [3:0]          reg_master,
  output logic [OUT_BITS-1:0] mix_out,
  output logic                mix_valid,
  output logic                err_overrun
);

  localparam int ACC_W = 11;
  localparam int SCL_W = 16;

  // Clamp bounds for the final output, held at the scaled-value width.
  localparam logic signed [SCL_W-1:0] SAT_HI = SCL_W'((1 << (OUT_BITS-1)) - 1);
  localparam logic signed [SCL_W-1:0] SAT_LO = SCL_W'(-(1 << (OUT_BITS-1)));

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_SCALE  = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic signed [ACC_W-1:0]    r_acc;
  logic signed [SCL_W-1:0]    r_scaled;
  logic        [OUT_BITS-1:0] r_mix_out;
  logic                       r_mix_valid;
  logic                       r_err_overrun;

  logic        [7:0]          w_mute_ext;
  logic signed [ACC_W-1:0]    w_sample_eff;
  logic signed [SCL_W-1:0]    w_acc_ext;
  logic signed [SCL_W-1:0]    w_gain;
  logic signed [SCL_W-1:0]    w_product;
  logic signed [SCL_W-1:0]    w_shifted;
  logic        [OUT_BITS-1:0] w_sat;

  logic w_load;
  logic w_add;
  logic w_scale;
  logic w_emit;
  logic w_overrun;

  // The 3-bit index can address up to 8 channels. Indices with no channel
  // behind them are treated as permanently muted, so they add nothing.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mute
      if (gi < CH_NUM) begin : g_real
        assign w_mute_ext[gi] = reg_mute[gi];
      end else begin : g_pad
        assign w_mute_ext[gi] = 1'b1;
      end
    end
  endgenerate

  assign w_sample_eff = w_mute_ext[ch_index] ? '0 : {{(ACC_W-8){channel[7]}}, channel};

  // The 16-bit signed product cannot overflow, since |acc| <= 1024 and the
  // gain is <= 16. An arithmetic shift rounds toward minus infinity.
  assign w_acc_ext = {{(SCL_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
  assign w_gain    = {{(SCL_W-4){1'b0}}, reg_master} + 16'd1;
  assign w_product = w_acc_ext * w_gain;
  assign w_shifted = w_product >>> 4;

  // Clamp the scaled value into the signed output range.
  always_comb begin
    w_sat = r_scaled[OUT_BITS-1:0];
    if (r_scaled > SAT_HI) begin
      w_sat = SAT_HI[OUT_BITS-1:0];
    end else if (r_scaled < SAT_LO) begin
      w_sat = SAT_LO[OUT_BITS-1:0];
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: a frame closes only on a qualified ch_last.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (ch_valid) begin
          w_state_next = ch_last ? ST_SCALE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (ch_valid && ch_last) begin
          w_state_next = ST_SCALE;
        end
      end
      ST_SCALE:  w_state_next = ST_OUTPUT;
      ST_OUTPUT: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Output decode: datapath enables for each state.
  always_comb begin
    w_load    = 1'b0;
    w_add     = 1'b0;
    w_scale   = 1'b0;
    w_emit    = 1'b0;
    w_overrun = 1'b0;
    case (r_state)
      ST_IDLE:   w_load = ch_valid;
      ST_ACCUM:  w_add  = ch_valid;
      ST_SCALE: begin
        w_scale   = 1'b1;
        w_overrun = ch_valid;
      end
      ST_OUTPUT: begin
        w_emit    = 1'b1;
        w_overrun = ch_valid;
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  // Datapath: accumulate, scale, saturate/present, and latch overrun.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_acc         <= '0;
      r_scaled      <= '0;
      r_mix_out     <= '0;
      r_mix_valid   <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_mix_valid <= w_emit;
      if (w_load) begin
        r_acc <= w_sample_eff;
      end else if (w_add) begin
        r_acc <= r_acc + w_sample_eff;
      end
      if (w_scale) begin
        r_scaled <= w_shifted;
      end
      if (w_emit) begin
        r_mix_out <= w_sat;
      end
      if (w_overrun) begin
        r_err_overrun <= 1'b1;
      end
    end
  end

  assign mix_out     = r_mix_out;
  assign mix_valid   = r_mix_valid;
  assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_wts_channel_mixer.sv
// Testbench for wts_channel_mixer. It drives an 11-bit and an 8-bit output
// instance in parallel, runs a directed vector table and hand-written
// overrun/reset sequences, then randomized frames against a reference model.
module tb_wts_channel_mixer;

  logic        clk;
  logic        nreset;
  logic        ch_valid;
  logic        ch_last;
  logic [2:0]  ch_index;
  logic [7:0]  channel;
  logic [4:0]  reg_mute;
  logic [3:0]  reg_master;

  logic signed [10:0] mix_out_a;
  logic               mix_valid_a;
  logic               err_a;
  logic signed [7:0]  mix_out_b;
  logic               mix_valid_b;
  logic               err_b;

  int n_vec = 0;
  int n_mis = 0;

  wts_channel_mixer #(.CH_NUM(5), .OUT_BITS(11)) dut_a (
    .clk(clk), .nreset(nreset), .ch_valid(ch_valid), .ch_last(ch_last),
    .ch_index(ch_index), .channel(channel), .reg_mute(reg_mute),
    .reg_master(reg_master), .mix_out(mix_out_a), .mix_valid(mix_valid_a),
    .err_overrun(err_a)
  );

  wts_channel_mixer #(.CH_NUM(5), .OUT_BITS(8)) dut_b (
    .clk(clk), .nreset(nreset), .ch_valid(ch_valid), .ch_last(ch_last),
    .ch_index(ch_index), .channel(channel), .reg_mute(reg_mute),
    .reg_master(reg_master), .mix_out(mix_out_b), .mix_valid(mix_valid_b),
    .err_overrun(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               n;
    logic [7:0][2:0]  idx;
    logic [7:0][7:0]  smp;
    logic [4:0]       mute;
    logic [3:0]       master;
    int               exp11;
    int               exp8;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: masked frame sum wrapped to the 11-bit accumulator, times
  // (master+1), divided by 16 with floor rounding, clamped to 'bits'.
  function automatic int model(input int n, input logic [7:0][2:0] idx,
                               input logic [7:0][7:0] smp, input logic [4:0] mute,
                               input int master, input int bits);
    int sum = 0;
    int p, q, hi, lo;
    for (int k = 0; k < n; k++) begin
      if (idx[k] < 3'd5) begin
        if (!mute[idx[k]]) sum += int'($signed(smp[k]));
      end
    end
    sum = ((sum % 2048) + 2048) % 2048;
    if (sum >= 1024) sum -= 2048;
    p = sum * (master + 1);
    q = p / 16;
    if (p < 0 && (p % 16) != 0) q = q - 1;
    hi = (1 << (bits - 1)) - 1;
    lo = -(1 << (bits - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q;
  endfunction

  function automatic vec_t mk(input int n, input int base, input int step,
                              input logic [4:0] mute, input logic [3:0] master,
                              input int e11, input int e8);
    vec_t v;
    v.n = n;
    v.idx = '0;
    v.smp = '0;
    for (int k = 0; k < n; k++) begin
      v.idx[k] = 3'(k);
      v.smp[k] = 8'(base + step * k);
    end
    v.mute = mute;
    v.master = master;
    v.exp11 = e11;
    v.exp8 = e8;
    return v;
  endfunction

  // Present one strobe at the current time (just after an edge) and return
  // just after the edge that samples it; idle inputs carry junk.
  task automatic strobe(input logic [2:0] idx, input logic [7:0] val, input logic last);
    ch_valid = 1'b1;
    ch_index = idx;
    channel  = val;
    ch_last  = last;
    @(posedge clk); #1;
    ch_valid = 1'b0;
    ch_last  = 1'b0;
    ch_index = 3'($urandom_range(0, 7));
    channel  = 8'($urandom);
  endtask

  task automatic send_frame(input int n, input logic [7:0][2:0] idx,
                            input logic [7:0][7:0] smp, input logic [4:0] mute,
                            input logic [3:0] master, input int maxgap);
    reg_mute   = mute;
    reg_master = master;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        repeat ($urandom_range(0, maxgap)) begin
          @(posedge clk); #1;
        end
      end
      strobe(idx[k], smp[k], k == n - 1);
    end
  endtask

  // Called just after the edge that took ch_last; checks exact latency,
  // single-cycle pulse and that mix_out holds afterwards.
  task automatic expect_frame(input int e11, input int e8, input string tag);
    @(posedge clk); #1;
    chk({tag, "_early"}, int'(mix_valid_a), 0);
    @(posedge clk); #1;
    chk({tag, "_valid11"}, int'(mix_valid_a), 1);
    chk({tag, "_valid8"}, int'(mix_valid_b), 1);
    chk({tag, "_out11"}, int'(mix_out_a), e11);
    chk({tag, "_out8"}, int'(mix_out_b), e8);
    $display("frame %s: out11=%0d out8=%0d (exp %0d/%0d)", tag,
             int'(mix_out_a), int'(mix_out_b), e11, e8);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, int'(mix_valid_a), 0);
    chk({tag, "_hold"}, int'(mix_out_a), e11);
  endtask

  vec_t vecs[9];

  initial begin
    logic [7:0][2:0] ridx;
    logic [7:0][7:0] rsmp;
    logic [4:0]      rmute;
    logic [3:0]      rmaster;
    int              rn;

    vecs[0] = mk(5, 10, 10, 5'b00000, 4'd15, 150, 127);
    vecs[1] = mk(5, 10, 10, 5'b00000, 4'd7, 75, 75);
    vecs[2] = mk(1, -1, 0, 5'b00000, 4'd0, -1, -1);
    vecs[3] = mk(5, 10, 10, 5'b00100, 4'd15, 120, 120);
    vecs[4] = mk(2, 100, -95, 5'b00000, 4'd15, 5, 5);
    vecs[4].idx[0] = 3'd6;
    vecs[4].idx[1] = 3'd0;
    vecs[5] = mk(5, -128, 0, 5'b00000, 4'd15, -640, -128);
    vecs[6] = mk(5, 127, 0, 5'b00000, 4'd15, 635, 127);
    vecs[7] = mk(5, -10, -10, 5'b00000, 4'd0, -10, -10);
    vecs[8] = mk(5, 10, 10, 5'b00000, 4'd0, 9, 9);

    nreset = 1'b0;
    ch_valid = 1'b0;
    ch_last = 1'b0;
    ch_index = 3'd0;
    channel = 8'd0;
    reg_mute = 5'd0;
    reg_master = 4'd15;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", int'(mix_out_a), 0);
    chk("reset_valid", int'(mix_valid_a), 0);
    chk("reset_err", int'(err_a), 0);
    nreset = 1'b1;
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      send_frame(vecs[i].n, vecs[i].idx, vecs[i].smp, vecs[i].mute, vecs[i].master, 0);
      expect_frame(vecs[i].exp11, vecs[i].exp8, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_err", i), int'(err_a), 0);
    end

    // Overrun: strobe during SCALE is dropped and flags a sticky error.
    send_frame(5, vecs[0].idx, vecs[0].smp, 5'b00000, 4'd15, 0);
    strobe(3'd0, 8'd99, 1'b0);
    chk("ovr_err_set", int'(err_a), 1);
    chk("ovr_valid_early", int'(mix_valid_a), 0);
    @(posedge clk); #1;
    chk("ovr_valid", int'(mix_valid_a), 1);
    chk("ovr_out", int'(mix_out_a), 150);
    $display("frame overrun: out11=%0d err=%0d", int'(mix_out_a), int'(err_a));
    @(posedge clk); #1;
    send_frame(5, vecs[0].idx, mk(5, 1, 1, 5'd0, 4'd15, 0, 0).smp, 5'b00000, 4'd15, 0);
    expect_frame(15, 15, "ovr_next");
    chk("ovr_err_sticky", int'(err_a), 1);
    chk("ovr_err_sticky8", int'(err_b), 1);

    // Reset mid-frame discards the partial sum and clears everything.
    for (int k = 0; k < 3; k++) strobe(3'(k), 8'd100, 1'b0);
    nreset = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_out", int'(mix_out_a), 0);
    chk("rst_mid_valid", int'(mix_valid_a), 0);
    chk("rst_mid_err", int'(err_a), 0);
    chk("rst_mid_out8", int'(mix_out_b), 0);
    $display("frame reset_mid: out11=%0d err=%0d", int'(mix_out_a), int'(err_a));
    nreset = 1'b1;
    @(posedge clk); #1;
    send_frame(5, vecs[0].idx, mk(5, 10, 0, 5'd0, 4'd15, 0, 0).smp, 5'b00000, 4'd15, 0);
    expect_frame(50, 50, "rst_after");

    // Randomized frames against the reference model, with idle gaps.
    for (int r = 0; r < 40; r++) begin
      rn = $urandom_range(1, 6);
      ridx = '0;
      rsmp = '0;
      for (int k = 0; k < rn; k++) begin
        ridx[k] = 3'($urandom_range(0, 7));
        rsmp[k] = 8'($urandom);
      end
      rmute = 5'($urandom);
      rmaster = 4'($urandom);
      send_frame(rn, ridx, rsmp, rmute, rmaster, 2);
      expect_frame(model(rn, ridx, rsmp, rmute, int'(rmaster), 11),
                   model(rn, ridx, rsmp, rmute, int'(rmaster), 8),
                   $sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_err", r), int'(err_a), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
